// File: rtl/eth_pkg.sv
// Shared constants, FSM state type and a saturating increment for the
// Ethernet RX classifier.
package eth_pkg;

  localparam logic [15:0] ETYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETYPE_ARP  = 16'h0806;
  localparam logic [47:0] MAC_BCAST  = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {HDR, FWD_IP, FWD_ARP, ARP_TAIL, DROP} eth_rx_state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-entry valid/ready register slice. It accepts a new beat whenever it is
// empty or draining in the same cycle, so it sustains 1 beat/cycle.
module axis_out_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);

  logic [W-1:0] data_q;
  logic         valid_q;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (in_ready_o) begin
      valid_q <= in_valid_i;
      if (in_valid_i) data_q <= in_data_i;
    end
  end

endmodule

// File: rtl/eth_rx_classifier.sv
// Ethernet RX classifier: parses the padded L2 header, filters on dst MAC and
// steers IPv4 / ARP payload. Define ETH_RX_STATS_EN to build the counters.
module eth_rx_classifier
  import eth_pkg::*;
#(
  parameter bit BCAST_ACCEPT = 1'b1,
  parameter int ARP_WORDS    = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic [3:0]  s_axis_tkeep,
  input  logic [47:0] i_local_mac,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tuser,
  output logic [31:0] o_arp_data,
  output logic        o_arp_valid,
  input  logic        i_arp_ready,
  output logic        o_arp_last,
  output logic [15:0] o_cnt_rx,
  output logic [15:0] o_cnt_arp,
  output logic [15:0] o_cnt_ip,
  output logic [15:0] o_cnt_drop
);

  localparam int             AW           = $clog2(ARP_WORDS + 1);
  localparam logic [AW-1:0]  ARP_LAST_IDX = AW'(ARP_WORDS - 1);
  localparam logic [AW-1:0]  ACNT_ONE     = AW'(1);

  eth_rx_state_t  state_q, state_d;
  logic [1:0]     wcnt_q;
  logic [AW-1:0]  acnt_q;
  logic [15:0]    dst_hi_q;
  logic [31:0]    dst_lo_q;

  logic beat, mac_ok, ip_rdy, arp_rdy, ip_load, arp_load, arp_last;

  assign beat   = s_axis_tvalid && s_axis_tready;
  assign mac_ok = ({dst_hi_q, dst_lo_q} == i_local_mac) ||
                  (BCAST_ACCEPT && ({dst_hi_q, dst_lo_q} == MAC_BCAST));

  always_ff @(posedge clk) begin
    if (rst) state_q <= HDR;
    else     state_q <= state_d;
  end

  // W3 is decided on the fly against the latched dst; tlast on any header word is a runt.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HDR:
        if (beat && !s_axis_tlast && wcnt_q == 2'd3) begin
          if (mac_ok && s_axis_tdata[15:0] == ETYPE_IPV4)     state_d = FWD_IP;
          else if (mac_ok && s_axis_tdata[15:0] == ETYPE_ARP) state_d = FWD_ARP;
          else                                                state_d = DROP;
        end
      FWD_IP:
        if (beat && s_axis_tlast) state_d = HDR;
      FWD_ARP:
        if (beat) begin
          if (s_axis_tlast)                state_d = HDR;
          else if (acnt_q == ARP_LAST_IDX) state_d = ARP_TAIL;
        end
      default:
        if (beat && s_axis_tlast) state_d = HDR;
    endcase
  end

  always_comb begin
    s_axis_tready = 1'b1;
    ip_load       = 1'b0;
    arp_load      = 1'b0;
    arp_last      = 1'b0;
    case (state_q)
      FWD_IP: begin
        s_axis_tready = ip_rdy;
        ip_load       = s_axis_tvalid && ip_rdy;
      end
      FWD_ARP: begin
        s_axis_tready = arp_rdy;
        arp_load      = s_axis_tvalid && arp_rdy;
        arp_last      = s_axis_tlast || (acnt_q == ARP_LAST_IDX);
      end
      default: ;
    endcase
  end

  // wcnt wraps 3->0 as the FSM leaves HDR, so it is already clear for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q   <= 2'd0;
      acnt_q   <= '0;
      dst_hi_q <= '0;
      dst_lo_q <= '0;
    end else begin
      if (beat && state_q == HDR) begin
        wcnt_q <= s_axis_tlast ? 2'd0 : wcnt_q + 2'd1;
        if (wcnt_q == 2'd0) dst_hi_q <= s_axis_tdata[15:0];
        if (wcnt_q == 2'd1) dst_lo_q <= s_axis_tdata;
      end
      if (arp_load) acnt_q <= arp_last ? '0 : acnt_q + ACNT_ONE;
    end
  end

  axis_out_reg #(.W(38)) u_ip_out (
    .clk        (clk),
    .rst        (rst),
    .in_data_i  ({s_axis_tdata, s_axis_tlast, s_axis_tkeep, dst_hi_q[8]}),
    .in_valid_i (ip_load),
    .in_ready_o (ip_rdy),
    .out_data_o ({m_axis_tdata, m_axis_tlast, m_axis_tkeep, m_axis_tuser}),
    .out_valid_o(m_axis_tvalid),
    .out_ready_i(m_axis_tready)
  );

  axis_out_reg #(.W(33)) u_arp_out (
    .clk        (clk),
    .rst        (rst),
    .in_data_i  ({s_axis_tdata, arp_last}),
    .in_valid_i (arp_load),
    .in_ready_o (arp_rdy),
    .out_data_o ({o_arp_data, o_arp_last}),
    .out_valid_o(o_arp_valid),
    .out_ready_i(i_arp_ready)
  );

`ifdef ETH_RX_STATS_EN
  logic [15:0] cnt_rx_q, cnt_arp_q, cnt_ip_q, cnt_drop_q;
  logic        hdr_beat, runt, decide;

  assign hdr_beat = beat && state_q == HDR;
  assign runt     = hdr_beat && s_axis_tlast;
  assign decide   = hdr_beat && !s_axis_tlast && wcnt_q == 2'd3;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_rx_q   <= '0;
      cnt_arp_q  <= '0;
      cnt_ip_q   <= '0;
      cnt_drop_q <= '0;
    end else begin
      if (beat && s_axis_tlast)                         cnt_rx_q   <= sat_inc(cnt_rx_q);
      if (decide && state_d == FWD_IP)                  cnt_ip_q   <= sat_inc(cnt_ip_q);
      if (decide && state_d == FWD_ARP)                 cnt_arp_q  <= sat_inc(cnt_arp_q);
      if (runt || (decide && state_d == DROP))          cnt_drop_q <= sat_inc(cnt_drop_q);
    end
  end

  assign o_cnt_rx   = cnt_rx_q;
  assign o_cnt_arp  = cnt_arp_q;
  assign o_cnt_ip   = cnt_ip_q;
  assign o_cnt_drop = cnt_drop_q;
`else
  assign o_cnt_rx   = 16'h0;
  assign o_cnt_arp  = 16'h0;
  assign o_cnt_ip   = 16'h0;
  assign o_cnt_drop = 16'h0;
`endif

endmodule

// File: tb/tb_eth_rx_classifier.sv
// Randomized self-checking bench: frames are classified by a queue-based
// reference model and egress beats are scoreboarded against it.
module tb_eth_rx_classifier;
  localparam logic [47:0] LOCAL = 48'h000A_3500_0102;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
  logic [3:0]  s_axis_tkeep = 4'hF;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready = 1'b1, m_axis_tlast, m_axis_tuser;
  logic [3:0]  m_axis_tkeep;
  logic [31:0] o_arp_data;
  logic        o_arp_valid, i_arp_ready = 1'b1, o_arp_last;
  logic [15:0] o_cnt_rx, o_cnt_arp, o_cnt_ip, o_cnt_drop;

  eth_rx_classifier dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tkeep(s_axis_tkeep), .i_local_mac(LOCAL),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .o_arp_data(o_arp_data), .o_arp_valid(o_arp_valid), .i_arp_ready(i_arp_ready),
    .o_arp_last(o_arp_last), .o_cnt_rx(o_cnt_rx), .o_cnt_arp(o_cnt_arp),
    .o_cnt_ip(o_cnt_ip), .o_cnt_drop(o_cnt_drop)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [31:0] frm[$];
  logic [37:0] exp_ip[$];
  logic [32:0] exp_arp[$];
  int   e_rx = 0, e_ip = 0, e_arp = 0, e_drop = 0;
  bit   rdy_rand = 1'b0, tready_low = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic mk_frame(input logic [47:0] dst, input logic [15:0] et, input int npay);
    logic [47:0] src;
    src = {$urandom, $urandom};
    frm.delete();
    frm.push_back({16'($urandom), dst[47:32]});
    frm.push_back(dst[31:0]);
    frm.push_back(src[47:16]);
    frm.push_back({src[15:0], et});
    for (int i = 0; i < npay; i++) frm.push_back($urandom);
  endtask

  // Reference classification of a whole frame held in frm.
  task automatic model(input logic [3:0] lkeep);
    int n, k;
    logic [47:0] dst;
    logic [15:0] et;
    n = frm.size();
    e_rx++;
    if (n <= 4) begin e_drop++; return; end
    dst = {frm[0][15:0], frm[1]};
    et  = frm[3][15:0];
    if ((dst == LOCAL || dst == BCAST) && et == 16'h0800) begin
      e_ip++;
      for (int i = 4; i < n; i++)
        exp_ip.push_back({frm[i], i == n-1, (i == n-1) ? lkeep : 4'hF, dst[40]});
    end else if ((dst == LOCAL || dst == BCAST) && et == 16'h0806) begin
      e_arp++;
      k = (n - 4 < 7) ? n - 4 : 7;
      for (int j = 0; j < k; j++) exp_arp.push_back({frm[4+j], j == k-1});
    end else e_drop++;
  endtask

  // Called #1 after a posedge; returns #1 after the posedge of the last accept.
  task automatic send_frame(input int nsend, input logic [3:0] lkeep, input bit gaps);
    bit acc;
    int t;
    for (int i = 0; i < nsend; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = frm[i];
      s_axis_tlast  = (i == frm.size() - 1);
      s_axis_tkeep  = (i == frm.size() - 1) ? lkeep : 4'hF;
      acc = 1'b0;
      t = 0;
      while (!acc) begin
        @(negedge clk);
        acc = s_axis_tready;
        if (!acc) tready_low = 1'b1;
        @(posedge clk); #1;
        t++;
        if (t > 2000) begin
          chk("send_timeout", 64'(t), 64'd0);
          $display("CHECKS %0d ERRORS %0d", checks, errors);
          $fatal(1, "stuck input");
        end
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((exp_ip.size() != 0 || exp_arp.size() != 0) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_ip_left"}, 64'(exp_ip.size()), 64'd0);
    chk({tag, "_arp_left"}, 64'(exp_arp.size()), 64'd0);
    exp_ip.delete();
    exp_arp.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_cnts(input string tag);
`ifdef ETH_RX_STATS_EN
    chk({tag, "_cnt_rx"},   64'(o_cnt_rx),   64'(e_rx));
    chk({tag, "_cnt_ip"},   64'(o_cnt_ip),   64'(e_ip));
    chk({tag, "_cnt_arp"},  64'(o_cnt_arp),  64'(e_arp));
    chk({tag, "_cnt_drop"}, 64'(o_cnt_drop), 64'(e_drop));
`else
    chk({tag, "_cnt_rx"},   64'(o_cnt_rx),   64'd0);
    chk({tag, "_cnt_drop"}, 64'(o_cnt_drop), 64'd0);
`endif
  endtask

  // Scoreboard: every transferred egress beat must match the model's next beat.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_ip.size() == 0) chk("ip_extra_beat", 64'(m_axis_tdata), 64'd0);
        else chk("ip_beat", 64'({m_axis_tdata, m_axis_tlast, m_axis_tkeep, m_axis_tuser}),
                 64'(exp_ip.pop_front()));
      end
      if (o_arp_valid && i_arp_ready) begin
        if (exp_arp.size() == 0) chk("arp_extra_beat", 64'(o_arp_data), 64'd0);
        else chk("arp_beat", 64'({o_arp_data, o_arp_last}), 64'(exp_arp.pop_front()));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_rand) begin
        m_axis_tready = ($urandom_range(0, 3) != 0);
        i_arp_ready   = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    logic [31:0] hold;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_arp_valid", 64'(o_arp_valid), 64'd0);
    chk("rst_m_flags", 64'({m_axis_tlast, m_axis_tuser, o_arp_last}), 64'd0);
    chk("rst_m_data", 64'({m_axis_tdata, m_axis_tkeep}), 64'd0);
    chk("rst_tready", 64'(s_axis_tready), 64'd1);
    chk_cnts("rst");
    @(posedge clk); #1;

    // Unicast IPv4, 6 payload words, short last beat
    mk_frame(LOCAL, 16'h0800, 6); model(4'h3); send_frame(frm.size(), 4'h3, 1'b0);
    drain("ipv4"); chk_cnts("ipv4");

    // Broadcast ARP with 12 payload words, then an IPv4 frame
    mk_frame(BCAST, 16'h0806, 12); model(4'hF); send_frame(frm.size(), 4'hF, 1'b0);
    mk_frame(LOCAL, 16'h0800, 3); model(4'h7); send_frame(frm.size(), 4'h7, 1'b0);
    drain("arp"); chk_cnts("arp");

    // Drops: wrong dst and unsupported etype, with egress fully stalled
    m_axis_tready = 1'b0; i_arp_ready = 1'b0; tready_low = 1'b0;
    mk_frame(48'h000A_3500_0103, 16'h0800, 5); model(4'hF); send_frame(frm.size(), 4'hF, 1'b0);
    mk_frame(LOCAL, 16'h86DD, 5); model(4'hF); send_frame(frm.size(), 4'hF, 1'b0);
    chk("drop_tready_low", 64'(tready_low), 64'd0);
    chk("drop_no_valid", 64'({m_axis_tvalid, o_arp_valid}), 64'd0);
    m_axis_tready = 1'b1; i_arp_ready = 1'b1;
    drain("drop"); chk_cnts("drop");

    // Runt followed by a valid frame
    mk_frame(LOCAL, 16'h0800, 0); void'(frm.pop_back()); model(4'hF); send_frame(frm.size(), 4'hF, 1'b0);
    mk_frame(LOCAL, 16'h0800, 4); model(4'h1); send_frame(frm.size(), 4'h1, 1'b0);
    drain("runt"); chk_cnts("runt");

    // Egress stall of 5 cycles mid-payload
    mk_frame(LOCAL, 16'h0800, 10); model(4'hF);
    fork
      send_frame(frm.size(), 4'hF, 1'b0);
      begin
        for (int t = 0; t < 100 && !m_axis_tvalid; t++) @(negedge clk);
        @(posedge clk); @(posedge clk); #1;
        m_axis_tready = 1'b0;
        @(negedge clk);
        hold = m_axis_tdata;
        for (int k = 0; k < 5; k++) begin
          chk("stall_data", 64'(m_axis_tdata), 64'(hold));
          chk("stall_tready", 64'({s_axis_tready, m_axis_tvalid}), 64'b01);
          @(negedge clk);
        end
        @(posedge clk); #1;
        m_axis_tready = 1'b1;
      end
    join
    drain("stall"); chk_cnts("stall");

    // Reset for one cycle in the middle of an ARP frame
    mk_frame(BCAST, 16'h0806, 10);
    for (int j = 0; j < 3; j++) exp_arp.push_back({frm[4+j], 1'b0});
    send_frame(7, 4'hF, 1'b0);
    i_arp_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_arp_valid", 64'(o_arp_valid), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_ip.delete(); exp_arp.delete();
    e_rx = 0; e_ip = 0; e_arp = 0; e_drop = 0;
    @(negedge clk);
    chk("post_rst_valids", 64'({m_axis_tvalid, o_arp_valid}), 64'd0);
    chk_cnts("post_rst");
    @(posedge clk); #1;
    i_arp_ready = 1'b1;
    mk_frame(LOCAL, 16'h0800, 2); model(4'hF); send_frame(frm.size(), 4'hF, 1'b0);
    drain("after_rst"); chk_cnts("after_rst");

    // Random mix of frame types, lengths, gaps and backpressure
    rdy_rand = 1'b1;
    for (int f = 0; f < 60; f++) begin
      int kind, np;
      logic [3:0] lk;
      kind = $urandom_range(0, 6);
      np   = $urandom_range(1, 14);
      lk   = 4'($urandom_range(1, 15));
      case (kind)
        0: mk_frame(LOCAL, 16'h0800, np);
        1: mk_frame(BCAST, 16'h0806, np);
        2: mk_frame(LOCAL, 16'h0806, np);
        3: mk_frame(LOCAL + 48'd1, 16'h0800, np);
        4: mk_frame(LOCAL, 16'h86DD, np);
        5: mk_frame(BCAST, 16'h0800, np);
        default: begin
          mk_frame(LOCAL, 16'h0800, 0);
          repeat ($urandom_range(0, 3)) void'(frm.pop_back());
        end
      endcase
      model(lk);
      send_frame(frm.size(), lk, 1'b1);
    end
    drain("rand");
    rdy_rand = 1'b0;
    m_axis_tready = 1'b1; i_arp_ready = 1'b1;
    chk_cnts("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
